// File: rtl/tlb_mutex_arb_if.sv
// Signal bundle between the translation FSMs, the TLB mutex arbiter and the shared TLB lookup port.
// "slave" is the arbiter side; "master" is the requester/TLB side.
interface tlb_mutex_arb_if #(
  parameter int N_CHAN    = 2,
  parameter int ADDR_BITS = 48,
  parameter int PID_BITS  = 6
);
  localparam int OW = $clog2(N_CHAN);

  // Lock handshake
  logic [N_CHAN-1:0]           lock_req;
  logic [N_CHAN-1:0]           unlock;
  logic [N_CHAN-1:0]           grant;
  logic [OW-1:0]               owner;
  logic                        busy;

  // Per-channel lookups, channel 0 in the LSBs
  logic [N_CHAN*ADDR_BITS-1:0] s_addr;
  logic [N_CHAN*PID_BITS-1:0]  s_pid;
  logic [N_CHAN-1:0]           s_wr;
  logic [N_CHAN-1:0]           s_strm;
  logic [N_CHAN-1:0]           s_valid;

  // Muxed lookup towards the TLB
  logic [ADDR_BITS-1:0]        m_addr;
  logic [PID_BITS-1:0]         m_pid;
  logic                        m_wr;
  logic                        m_strm;
  logic                        m_valid;

  // Status
  logic                        viol;
  logic                        wdog_irq;
  logic [OW-1:0]               wdog_ch;

  modport slave (
    input  lock_req, unlock, s_addr, s_pid, s_wr, s_strm, s_valid,
    output grant, owner, busy, m_addr, m_pid, m_wr, m_strm, m_valid,
    output viol, wdog_irq, wdog_ch
  );

  modport master (
    output lock_req, unlock, s_addr, s_pid, s_wr, s_strm, s_valid,
    input  grant, owner, busy, m_addr, m_pid, m_wr, m_strm, m_valid,
    input  viol, wdog_irq, wdog_ch
  );
endinterface

// File: rtl/tlb_mutex_arb.sv
// N-channel round-robin mutex guarding the shared TLB lookup port; the owner's lookup is muxed to the TLB.
// Optional hold watchdog enabled by defining TLB_ARB_WDOG_EN.
module tlb_mutex_arb #(
  parameter int N_CHAN    = 2,
  parameter int ADDR_BITS = 48,
  parameter int PID_BITS  = 6,
  parameter int WDOG_CYC  = 1024
) (
  input logic             aclk,
  input logic             aresetn,
  tlb_mutex_arb_if.slave  bus
);
   localparam int OW = $clog2(N_CHAN);
   localparam int HW = $clog2(WDOG_CYC) + 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t            state;
   logic [N_CHAN-1:0] grant_q;
   logic [OW-1:0]     owner_q;
   logic [OW-1:0]     rr_q;
   logic              busy_q;
   logic [HW-1:0]     hold_cnt;
   logic              viol_q;

   logic [OW-1:0]     pick_idx;
   logic              pick_vld;
   logic [OW-1:0]     owner_succ;
   logic              unlock_own;
   logic              wdog_fire;
   logic [N_CHAN-1:0] stray;

   // First requester at or after the round-robin pointer, wrapping.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      pick_idx = '0;
      pick_vld = 1'b0;
      for (int k = 0; k < N_CHAN; k++) begin
         if (!pick_vld && bus.lock_req[(int'(rr_q) + k) % N_CHAN]) begin
            pick_vld = 1'b1;
            pick_idx = OW'((int'(rr_q) + k) % N_CHAN);
         end
      end
   end

   assign owner_succ = (int'(owner_q) == N_CHAN - 1) ? '0 : owner_q + OW'(1);
   assign unlock_own = bus.unlock[owner_q];

`ifdef TLB_ARB_WDOG_EN
   logic          wdog_irq_q;
   logic [OW-1:0] wdog_ch_q;

   // An owner unlock in the expiry cycle takes precedence over eviction.
   assign wdog_fire = (state == LOCKED) && !unlock_own && (hold_cnt == HW'(WDOG_CYC - 1));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wdog_irq_q <= 1'b0;
         wdog_ch_q  <= '0;
      end else begin
         wdog_irq_q <= wdog_fire;
         if (wdog_fire) wdog_ch_q <= owner_q;
      end
   end

   assign bus.wdog_irq = wdog_irq_q;
   assign bus.wdog_ch  = wdog_ch_q;
`else
   logic unused_hold_cnt;

   // Hold counter is kept for debug visibility only in this build.
   assign wdog_fire       = 1'b0;
   assign unused_hold_cnt = ^hold_cnt;
   assign bus.wdog_irq    = 1'b0;
   assign bus.wdog_ch     = '0;
`endif

   // Ownership FSM; grant, owner and busy are registered alongside the state.
   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= IDLE;
         grant_q  <= '0;
         owner_q  <= '0;
         rr_q     <= '0;
         busy_q   <= 1'b0;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state    <= LOCKED;
                  busy_q   <= 1'b1;
                  grant_q  <= N_CHAN'(1) << pick_idx;
                  owner_q  <= pick_idx;
                  hold_cnt <= '0;
               end
            end
            LOCKED: begin
               if (unlock_own || wdog_fire) begin
                  state   <= IDLE;
                  busy_q  <= 1'b0;
                  grant_q <= '0;
                  rr_q    <= owner_succ;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: begin
               state   <= IDLE;
               busy_q  <= 1'b0;
               grant_q <= '0;
            end
         endcase
      end
   end

   // grant_q is zero while idle, so every unlock/valid outside the owner's bit is stray.
   assign stray = (bus.unlock | bus.s_valid) & ~grant_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) viol_q <= 1'b0;
      else          viol_q <= |stray;
   end

   assign bus.grant   = grant_q;
   assign bus.owner   = owner_q;
   assign bus.busy    = busy_q;
   assign bus.viol    = viol_q;

   assign bus.m_addr  = bus.s_addr[int'(owner_q)*ADDR_BITS +: ADDR_BITS];
   assign bus.m_pid   = bus.s_pid[int'(owner_q)*PID_BITS +: PID_BITS];
   assign bus.m_wr    = bus.s_wr[owner_q];
   assign bus.m_strm  = bus.s_strm[owner_q];
   assign bus.m_valid = busy_q & bus.s_valid[owner_q];

endmodule

// File: tb/tb_tlb_mutex_arb.sv
// Directed bench for tlb_mutex_arb (N_CHAN=4, WDOG_CYC=8) with a cycle-level reference model
// and a per-cycle compare process; watchdog section follows TLB_ARB_WDOG_EN.
module tb_tlb_mutex_arb;
  localparam int N  = 4;
  localparam int AB = 48;
  localparam int PB = 6;
  localparam int WC = 8;
`ifdef TLB_ARB_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  bit   chk_en  = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  always #5 aclk = ~aclk;

  tlb_mutex_arb_if #(.N_CHAN(N), .ADDR_BITS(AB), .PID_BITS(PB)) bus ();

  tlb_mutex_arb #(.N_CHAN(N), .ADDR_BITS(AB), .PID_BITS(PB), .WDOG_CYC(WC)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  // Reference model: who owns the mutex, where the round-robin search starts, how long it has been held.
  bit m_busy;
  int m_owner, m_rr, m_held, m_wch;
  bit m_viol, m_irq;

  always @(posedge aclk or negedge aresetn) begin : model
    int  own;
    bit  nviol, nirq;
    if (!aresetn) begin
      m_busy = 0; m_owner = 0; m_rr = 0; m_held = 0;
      m_viol = 0; m_irq = 0; m_wch = 0;
    end else begin
      own   = m_busy ? (1 << m_owner) : 0;
      nviol = ((int'(bus.unlock) & ~own) != 0) || ((int'(bus.s_valid) & ~own) != 0);
      nirq  = 0;
      if (m_busy) begin
        if (bus.unlock[m_owner]) begin
          m_busy = 0;
          m_rr   = (m_owner + 1) % N;
        end else if (WDOG && m_held == WC - 1) begin
          m_busy = 0;
          m_rr   = (m_owner + 1) % N;
          nirq   = 1;
          m_wch  = m_owner;
        end else begin
          m_held++;
        end
      end else if (bus.lock_req != '0) begin
        for (int k = 0; k < N; k++) begin
          if (bus.lock_req[(m_rr + k) % N]) begin
            m_owner = (m_rr + k) % N;
            break;
          end
        end
        m_busy = 1;
        m_held = 0;
      end
      m_viol = nviol;
      m_irq  = nirq;
    end
  end

  always @(negedge aclk) begin : compare
    logic [N-1:0] eg;
    if (chk_en) begin
      eg = m_busy ? (N'(1) << m_owner) : '0;
      check("grant",    bus.grant,    eg);
      check("owner",    bus.owner,    m_owner);
      check("busy",     bus.busy,     m_busy);
      check("m_valid",  bus.m_valid,  m_busy && bus.s_valid[m_owner]);
      check("m_addr",   bus.m_addr,   bus.s_addr[m_owner*AB +: AB]);
      check("m_pid",    bus.m_pid,    bus.s_pid[m_owner*PB +: PB]);
      check("m_wr",     bus.m_wr,     bus.s_wr[m_owner]);
      check("m_strm",   bus.m_strm,   bus.s_strm[m_owner]);
      check("viol",     bus.viol,     m_viol);
      check("wdog_irq", bus.wdog_irq, m_irq);
      check("wdog_ch",  bus.wdog_ch,  m_wch);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int cnt [N];
    int n;
    bus.lock_req = '0;
    bus.unlock   = '0;
    bus.s_valid  = '0;
    bus.s_wr     = 4'b0110;
    bus.s_strm   = 4'b1001;
    for (int i = 0; i < N; i++) begin
      bus.s_addr[i*AB +: AB] = 48'h1000_0000_0000 + AB'(i) * 48'h0000_0100_0040;
      bus.s_pid[i*PB +: PB]  = PB'(i + 5);
      cnt[i] = 0;
    end
    bus.s_addr[2*AB +: AB] = 48'h7F_0000_1000;

    // Reset values
    repeat (3) @(posedge aclk);
    #1;
    check("rst_grant",    bus.grant,    0);
    check("rst_owner",    bus.owner,    0);
    check("rst_busy",     bus.busy,     0);
    check("rst_m_valid",  bus.m_valid,  0);
    check("rst_viol",     bus.viol,     0);
    check("rst_wdog_irq", bus.wdog_irq, 0);
    check("rst_wdog_ch",  bus.wdog_ch,  0);
    aresetn = 1'b1;
    chk_en  = 1'b1;

    // First grant from rr=0, release, then the pending channel after one idle cycle
    bus.lock_req = 4'b1010;
    step();
    check("t1_grant", bus.grant, 4'b0010);
    check("t1_owner", bus.owner, 1);
    check("t1_busy",  bus.busy,  1);
    bus.lock_req = 4'b1000;
    bus.unlock   = 4'b0010;
    step();
    bus.unlock = '0;
    check("t1_idle_busy",  bus.busy,  0);
    check("t1_idle_grant", bus.grant, 0);
    check("t1_idle_owner", bus.owner, 1);
    step();
    check("t1_next_grant", bus.grant, 4'b1000);
    check("t1_next_owner", bus.owner, 3);
    bus.lock_req = '0;
    bus.unlock   = 4'b1000;
    step();
    bus.unlock = '0;
    check("t1_rel_busy", bus.busy, 0);

    // Non-owner unlock is ignored and flagged
    bus.lock_req = 4'b0010;
    step();
    check("nu_grant", bus.grant, 4'b0010);
    bus.lock_req = '0;
    bus.unlock   = 4'b1000;
    step();
    bus.unlock = '0;
    check("nu_viol",  bus.viol,  1);
    check("nu_busy",  bus.busy,  1);
    check("nu_grant_hold", bus.grant, 4'b0010);
    step();
    check("nu_viol_clr", bus.viol, 0);
    bus.unlock = 4'b0011;
    step();
    bus.unlock = '0;
    check("multi_unlock_busy", bus.busy, 0);
    check("multi_unlock_viol", bus.viol, 1);

    // Unlock while idle
    bus.unlock = 4'b0001;
    step();
    bus.unlock = '0;
    check("idle_unlock_viol", bus.viol, 1);
    check("idle_unlock_busy", bus.busy, 0);
    step();

    // Lookup mux with a stray valid from channel 0
    bus.lock_req = 4'b0100;
    step();
    check("mux_owner", bus.owner, 2);
    bus.lock_req = '0;
    bus.s_valid  = 4'b0101;
    #1;
    check("mux_m_valid", bus.m_valid, 1);
    check("mux_m_addr",  bus.m_addr,  48'h7F_0000_1000);
    check("mux_m_pid",   bus.m_pid,   7);
    step();
    check("mux_viol", bus.viol, 1);
    bus.s_valid = '0;
    step();
    check("mux_viol_clr", bus.viol, 0);
    bus.unlock = 4'b0100;
    step();
    bus.unlock = '0;

    // Asynchronous reset mid-lock (rr=3, so channel 2 wins after wrap)
    bus.lock_req = 4'b0100;
    step();
    check("ar_owner", bus.owner, 2);
    bus.lock_req = '0;
    bus.s_valid  = 4'b0100;
    #2;
    aresetn = 1'b0;
    #1;
    check("ar_grant",   bus.grant,   0);
    check("ar_busy",    bus.busy,    0);
    check("ar_m_valid", bus.m_valid, 0);
    bus.s_valid = '0;
    step();
    aresetn = 1'b1;
    bus.lock_req = 4'b1111;
    step();
    check("ar_regrant", bus.grant, 4'b0001);

    // Fairness: everyone requests continuously, owner unlocks 3 cycles after grant
    for (int g = 0; g < 16; g++) begin
      n = 0;
      while (!bus.busy && n < 8) begin
        step();
        n++;
      end
      check("fair_grant_seen", bus.busy, 1);
      if (g < 5) check("fair_order", bus.owner, g % N);
      if (int'(bus.owner) < N) cnt[bus.owner]++;
      step();
      step();
      bus.unlock = N'(1) << bus.owner;
      step();
      bus.unlock = '0;
      if (g == 15) bus.lock_req = '0;
    end
    for (int i = 0; i < N; i++) check("fair_count", cnt[i], 4);
    step();

    // Owner 2 never unlocks; channels 0, 1 and 3 wait
    bus.lock_req = 4'b0100;
    step();
    check("wd_owner", bus.owner, 2);
    bus.lock_req = 4'b1011;
`ifdef TLB_ARB_WDOG_EN
    for (int i = 0; i < 7; i++) begin
      step();
      check("wd_held", bus.busy, 1);
    end
    step();
    check("wd_release_busy", bus.busy,     0);
    check("wd_irq",          bus.wdog_irq, 1);
    check("wd_ch",           bus.wdog_ch,  2);
    step();
    check("wd_next_grant", bus.grant,    4'b1000);
    check("wd_irq_clr",    bus.wdog_irq, 0);
    bus.lock_req = '0;
    bus.s_valid  = 4'b0100;
    step();
    check("wd_evicted_viol", bus.viol, 1);
    bus.s_valid = '0;
`else
    for (int i = 0; i < 12; i++) begin
      step();
      check("nowd_held", bus.busy,     1);
      check("nowd_irq",  bus.wdog_irq, 0);
    end
    bus.unlock = 4'b0100;
    step();
    bus.unlock = '0;
    step();
    check("nowd_next_grant", bus.grant, 4'b1000);
    bus.lock_req = '0;
`endif
    bus.unlock = 4'b1000;
    step();
    bus.unlock = '0;
    repeat (3) step();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlb_mutex_arb.md
Name: tlb_mutex_arb

Overview:
- Parametrised N-channel successor to the per-vFPGA two-way rd/wr TLB mutex.
- Arbitrates exclusive ownership of one shared TLB lookup port among N_CHAN translation FSMs (rd, wr and extra channels such as RDMA and invalidation).
- Ownership is granted round-robin and held until the owner unlocks; the owner's lookup signals are muxed onto the TLB.
- Sits between the tlb_fsm instances and tlb_controller inside the MMU region.

Parameters:
- N_CHAN, 2, number of requesting channels (2..16).
- ADDR_BITS, 48, lookup virtual address width.
- PID_BITS, 6, process ID width.
- WDOG_CYC, 1024, watchdog hold limit in cycles (used only with the optional feature).

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- lock_req  in  N_CHAN  per-channel level lock request
- unlock  in  N_CHAN  per-channel single-cycle release pulse
- grant  out  N_CHAN  one-hot ownership, registered
- owner  out  $clog2(N_CHAN)  index of current/last owner
- busy  out  1  mutex held
- s_addr  in  N_CHAN*ADDR_BITS  per-channel lookup address, packed, channel 0 in LSBs
- s_pid  in  N_CHAN*PID_BITS  per-channel PID, packed
- s_wr  in  N_CHAN  per-channel write flag
- s_strm  in  N_CHAN  per-channel stream flag
- s_valid  in  N_CHAN  per-channel lookup valid
- m_addr  out  ADDR_BITS  muxed lookup address to TLB
- m_pid  out  PID_BITS  muxed PID
- m_wr  out  1  muxed write flag
- m_strm  out  1  muxed stream flag
- m_valid  out  1  muxed lookup valid
- viol  out  1  single-cycle pulse: a non-owner drove s_valid or unlock
- wdog_irq  out  1  single-cycle pulse on forced release
- wdog_ch  out  $clog2(N_CHAN)  channel that was force-released

Behaviour:
- Reset (async, aresetn=0): grant=0, owner=0, busy=0, m_valid=0, viol=0, wdog_irq=0, wdog_ch=0. Round-robin pointer rr=0 and hold_cnt=0. Reset mid-lock drops ownership immediately, with no unlock required.
- FSM states:
  - IDLE: busy=0.
  - LOCKED: busy=1, grant=onehot(owner).
- IDLE -> LOCKED: on any set lock_req bit, pick the first set bit searching from rr upward with wrap. grant, owner and busy register next edge (latency 1 cycle from request).
- lock_req is level. The requester holds it until it sees its grant bit; lock_req while LOCKED is held pending, never dropped.
- LOCKED -> IDLE: unlock[owner]=1. Next edge sets busy=0, grant=0, rr=(owner+1) mod N_CHAN; owner keeps its value.
- At least one IDLE cycle separates consecutive grants, including when the owner unlocks and re-requests in the same cycle.
- unlock from a non-owner, or while IDLE: ignored, viol pulses the next cycle.
- Several channels unlocking simultaneously: only the owner's bit acts; viol pulses.
- Lookup mux (combinational from the owner register):
  - m_addr, m_pid, m_wr and m_strm always show the owner's slice (stable while IDLE).
  - m_valid = busy & s_valid[owner].
  - s_valid from any non-owner is blocked and pulses viol the next cycle.
- hold_cnt:
  - Clears on grant and increments each LOCKED cycle.
  - Width $clog2(WDOG_CYC)+1; saturates, never wraps.
- Fairness: with all channels requesting continuously, each channel is granted exactly once per N_CHAN grants.

Optional Feature:
- TLB_ARB_WDOG_EN defined:
  - If LOCKED and hold_cnt == WDOG_CYC-1 with no unlock that cycle, force LOCKED -> IDLE next edge.
  - On that edge: wdog_irq pulses 1 cycle, wdog_ch=owner, rr=owner+1.
  - An unlock in the same cycle as expiry wins: normal release, no irq.
  - Ensuing lookups from the evicted channel raise viol.
- TLB_ARB_WDOG_EN undefined: no forced release; wdog_irq=0 and wdog_ch=0 constant; hold_cnt is kept for debug only.

Test Plan:
- Reset, N_CHAN=4, lock_req=4'b1010 -> grant=4'b0010 one cycle later, owner=1, busy=1. unlock[1] -> IDLE one cycle later. The next grant is 4'b1000 after one IDLE cycle.
- All 4 requesting continuously, each unlocking 3 cycles after grant -> grant order 0,1,2,3,0; 16 grants give 4 per channel.
- Owner=2 with s_valid=4'b0101, s_addr[2]=0x7F_0000_1000 -> m_valid=1, m_addr=0x7F_0000_1000; viol pulses for channel 0's valid.
- unlock[3] while owner=1 -> state stays LOCKED, viol=1 for one cycle, grant unchanged.
- Deassert aresetn asynchronously mid-lock -> grant=0, busy=0 and m_valid=0 immediately. After reset release, lock_req=4'b1111 -> grant=4'b0001.
- TLB_ARB_WDOG_EN defined, WDOG_CYC=8, owner 2 never unlocks -> forced release after 8 LOCKED cycles, wdog_irq pulses once, wdog_ch=2, next grant goes to channel 3.
